// File: rtl/combo_pkg.sv
// Shared constants, channel action encoding and the multiplier tier lookup
// for the combo tracker.
package combo_pkg;

  localparam int unsigned TIER2_MIN      = 10;
  localparam int unsigned TIER3_MIN      = 25;
  localparam int unsigned TIER4_MIN      = 50;
  localparam int unsigned MULT_W         = 3;
  localparam int unsigned MAX_COMBO_DEF  = 99;
  localparam int unsigned FULL_BONUS_DEF = 2;

  // Winning event for one channel in one cycle, after priority resolution.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_RESTART,
    ACT_MISS,
    ACT_FULL,
    ACT_HIT,
    ACT_TIMEOUT
  } act_e;

  // Score multiplier tier for a given combo count.
  function automatic logic [MULT_W-1:0] mult_of(input int unsigned c);
    if (c >= TIER4_MIN)      return MULT_W'(4);
    else if (c >= TIER3_MIN) return MULT_W'(3);
    else if (c >= TIER2_MIN) return MULT_W'(2);
    else                     return MULT_W'(1);
  endfunction

endpackage

// File: rtl/combo_tracker_if.sv
// Game-event inputs and per-channel combo outputs of the combo tracker.
interface combo_tracker_if
  import combo_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 7
) ();

  logic                       restart;
  logic [NUM_CH-1:0]          miss;
  logic [NUM_CH-1:0]          hit;
  logic [NUM_CH-1:0]          full_clear_hit;
  logic [NUM_CH*CNT_W-1:0]    combo_count;
  logic [NUM_CH*CNT_W-1:0]    best_combo;
  logic [NUM_CH*MULT_W-1:0]   multiplier;
  logic [NUM_CH-1:0]          combo_broken;

  modport master (
    output restart, miss, hit, full_clear_hit,
    input  combo_count, best_combo, multiplier, combo_broken
  );

  modport slave (
    input  restart, miss, hit, full_clear_hit,
    output combo_count, best_combo, multiplier, combo_broken
  );

endinterface

// File: rtl/combo_channel.sv
// One player channel: saturating combo count, idle-decay timer, best value
// and a one-cycle broken pulse.
module combo_channel
  import combo_pkg::*;
#(
  parameter int unsigned CNT_W       = 7,
  parameter int unsigned MAX_COMBO   = MAX_COMBO_DEF,
  parameter int unsigned FULL_BONUS  = FULL_BONUS_DEF,
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart_i,
  input  logic             miss_i,
  input  logic             hit_i,
  input  logic             full_clear_hit_i,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] best_o,
  output logic             broken_o
);

  localparam logic [CNT_W:0]   MAX_EXT   = (CNT_W+1)'(MAX_COMBO);
  localparam logic [CNT_W:0]   BONUS_EXT = (CNT_W+1)'(FULL_BONUS);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_COMBO);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] best_q, best_d;
  logic             broken_q, broken_d;
  logic             expire;
  logic [CNT_W:0]   sum_full, sum_hit;
  act_e             act;

  assign sum_full = {1'b0, count_q} + BONUS_EXT;
  assign sum_hit  = {1'b0, count_q} + (CNT_W+1)'(1);

  // Resolve simultaneous events: restart > miss > full clear > hit > timeout.
  always_comb begin
    act = ACT_HOLD;
    if (restart_i)             act = ACT_RESTART;
    else if (miss_i)           act = ACT_MISS;
    else if (full_clear_hit_i) act = ACT_FULL;
    else if (hit_i)            act = ACT_HIT;
    else if (expire)           act = ACT_TIMEOUT;
  end

  // Next count, broken pulse and running best.
  always_comb begin
    count_d  = count_q;
    broken_d = 1'b0;
    case (act)
      ACT_RESTART: count_d = '0;
      ACT_MISS: begin
        count_d  = '0;
        broken_d = (count_q != '0);
      end
      ACT_FULL:    count_d = (sum_full > MAX_EXT) ? MAX_CNT : sum_full[CNT_W-1:0];
      ACT_HIT:     count_d = (sum_hit  > MAX_EXT) ? MAX_CNT : sum_hit[CNT_W-1:0];
      ACT_TIMEOUT: begin
        count_d  = '0;
        broken_d = 1'b1;
      end
      default: ;
    endcase
    best_d = (count_d > best_q) ? count_d : best_q;
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      best_q   <= '0;
      broken_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      best_q   <= best_d;
      broken_q <= broken_d;
    end
  end

  generate
    if (TIMEOUT_CYC > 0) begin : g_timer
      localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
      logic [TMR_W-1:0] timer_q, timer_d;

      // Expiry only matters for a live combo; the timer sits at 0 otherwise.
      assign expire = (count_q != '0) && (timer_q == TMR_W'(TIMEOUT_CYC - 1));

      // Any resolved event (including the timeout itself) reloads the timer.
      always_comb begin
        timer_d = timer_q;
        if (act != ACT_HOLD)     timer_d = '0;
        else if (count_q != '0)  timer_d = timer_q + TMR_W'(1);
      end

      // Idle timer register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
      end
    end else begin : g_no_timer
      assign expire = 1'b0;
    end
  endgenerate

  assign count_o  = count_q;
  assign best_o   = best_q;
  assign broken_o = broken_q;

endmodule

// File: rtl/combo_tracker.sv
// Multi-channel combo tracker: one independent combo_channel per player plus
// the combinational multiplier tier per channel.
module combo_tracker
  import combo_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = 7,
  parameter int unsigned MAX_COMBO   = MAX_COMBO_DEF,
  parameter int unsigned FULL_BONUS  = FULL_BONUS_DEF,
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic            clk,
  input  logic            rst,
  combo_tracker_if.slave  bus
);

  logic [NUM_CH*CNT_W-1:0]  count_w;
  logic [NUM_CH*CNT_W-1:0]  best_w;
  logic [NUM_CH*MULT_W-1:0] mult_w;
  logic [NUM_CH-1:0]        broken_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    combo_channel #(
      .CNT_W       (CNT_W),
      .MAX_COMBO   (MAX_COMBO),
      .FULL_BONUS  (FULL_BONUS),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_ch (
      .clk              (clk),
      .rst              (rst),
      .restart_i        (bus.restart),
      .miss_i           (bus.miss[i]),
      .hit_i            (bus.hit[i]),
      .full_clear_hit_i (bus.full_clear_hit[i]),
      .count_o          (count_w[i*CNT_W +: CNT_W]),
      .best_o           (best_w[i*CNT_W +: CNT_W]),
      .broken_o         (broken_w[i])
    );

    assign mult_w[i*MULT_W +: MULT_W] = mult_of(32'(count_w[i*CNT_W +: CNT_W]));
  end

  assign bus.combo_count  = count_w;
  assign bus.best_combo   = best_w;
  assign bus.multiplier   = mult_w;
  assign bus.combo_broken = broken_w;

endmodule

// File: tb/tb_combo_tracker.sv
// Directed bench: dut_a has decay disabled, dut_b decays after 16 idle cycles.
module tb_combo_tracker;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  combo_tracker_if #(.NUM_CH(2), .CNT_W(7)) if_a ();
  combo_tracker_if #(.NUM_CH(2), .CNT_W(7)) if_b ();

  combo_tracker #(
    .NUM_CH(2), .CNT_W(7), .MAX_COMBO(99), .FULL_BONUS(2), .TIMEOUT_CYC(0)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  combo_tracker #(
    .NUM_CH(2), .CNT_W(7), .MAX_COMBO(99), .FULL_BONUS(2), .TIMEOUT_CYC(16)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic [1:0] m, input logic [1:0] h, input logic [1:0] f,
                         input logic rs);
    if_a.miss = m; if_a.hit = h; if_a.full_clear_hit = f; if_a.restart = rs;
    @(posedge clk); #1;
    if_a.miss = '0; if_a.hit = '0; if_a.full_clear_hit = '0; if_a.restart = 1'b0;
  endtask

  task automatic drive_b(input logic [1:0] m, input logic [1:0] h, input logic [1:0] f,
                         input logic rs);
    if_b.miss = m; if_b.hit = h; if_b.full_clear_hit = f; if_b.restart = rs;
    @(posedge clk); #1;
    if_b.miss = '0; if_b.hit = '0; if_b.full_clear_hit = '0; if_b.restart = 1'b0;
  endtask

  int unsigned thr   [6] = '{9, 10, 24, 25, 49, 50};
  int unsigned exp_m [6] = '{1, 2, 2, 3, 3, 4};

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    if_a.miss = '0; if_a.hit = '0; if_a.full_clear_hit = '0; if_a.restart = 1'b0;
    if_b.miss = '0; if_b.hit = '0; if_b.full_clear_hit = '0; if_b.restart = 1'b0;
    #2 rst = 1'b1;
    #3;
    check("rst_a_count",  32'(if_a.combo_count), 0);
    check("rst_a_best",   32'(if_a.best_combo), 0);
    check("rst_a_mult",   32'(if_a.multiplier), 32'h9);
    check("rst_a_broken", 32'(if_a.combo_broken), 0);
    check("rst_b_count",  32'(if_b.combo_count), 0);
    check("rst_b_mult",   32'(if_b.multiplier), 32'h9);
    #10 rst = 1'b0;
    drive_a(2'b00, 2'b00, 2'b00, 1'b0);
    check("post_rst_mult", 32'(if_a.multiplier), 32'h9);

    // ch0 to 30, then miss breaks it once; a second miss at 0 is silent.
    for (int i = 0; i < 30; i++) drive_a(2'b00, 2'b01, 2'b00, 1'b0);
    check("a30_count", 32'(if_a.combo_count[6:0]), 30);
    check("a30_mult",  32'(if_a.multiplier[2:0]), 3);
    drive_a(2'b01, 2'b00, 2'b00, 1'b0);
    check("miss_count",  32'(if_a.combo_count[6:0]), 0);
    check("miss_broken", 32'(if_a.combo_broken), 32'h1);
    check("miss_best",   32'(if_a.best_combo[6:0]), 30);
    check("miss_mult",   32'(if_a.multiplier[2:0]), 1);
    drive_a(2'b00, 2'b00, 2'b00, 1'b0);
    check("broken_1cyc", 32'(if_a.combo_broken), 0);
    drive_a(2'b01, 2'b00, 2'b00, 1'b0);
    check("miss0_nopulse", 32'(if_a.combo_broken), 0);

    // Saturation: 98 hits, full clear -> 99, further hit/full clear stay 99.
    for (int i = 0; i < 98; i++) drive_a(2'b00, 2'b01, 2'b00, 1'b0);
    check("a98_count", 32'(if_a.combo_count[6:0]), 98);
    check("a98_mult",  32'(if_a.multiplier[2:0]), 4);
    drive_a(2'b00, 2'b00, 2'b01, 1'b0);
    check("sat_full", 32'(if_a.combo_count[6:0]), 99);
    check("sat_best", 32'(if_a.best_combo[6:0]), 99);
    drive_a(2'b00, 2'b01, 2'b00, 1'b0);
    check("sat_hit", 32'(if_a.combo_count[6:0]), 99);
    drive_a(2'b00, 2'b00, 2'b01, 1'b0);
    check("sat_full2", 32'(if_a.combo_count[6:0]), 99);
    check("ch1_idle",  32'(if_a.combo_count[13:7]), 0);

    // Same-cycle priority: ch0 hit+miss -> 0; ch1 at 10 full+hit -> 12.
    for (int i = 0; i < 10; i++) drive_a(2'b00, 2'b10, 2'b00, 1'b0);
    check("ch1_10",    32'(if_a.combo_count[13:7]), 10);
    check("ch0_indep", 32'(if_a.combo_count[6:0]), 99);
    drive_a(2'b01, 2'b11, 2'b10, 1'b0);
    check("prio_ch0",      32'(if_a.combo_count[6:0]), 0);
    check("prio_ch1",      32'(if_a.combo_count[13:7]), 12);
    check("prio_broken",   32'(if_a.combo_broken), 32'h1);
    check("prio_ch1_best", 32'(if_a.best_combo[13:7]), 12);

    // Multiplier tier boundaries on ch1 after a restart.
    drive_a(2'b00, 2'b00, 2'b00, 1'b1);
    check("restart_a_count",  32'(if_a.combo_count), 0);
    check("restart_a_broken", 32'(if_a.combo_broken), 0);
    check("restart_a_best0",  32'(if_a.best_combo[6:0]), 99);
    for (int n = 1; n <= 50; n++) begin
      drive_a(2'b00, 2'b10, 2'b00, 1'b0);
      for (int k = 0; k < 6; k++)
        if (n == int'(thr[k]))
          check($sformatf("mult_at_%0d", n), 32'(if_a.multiplier[5:3]), exp_m[k]);
    end

    // Restart leaves best alone: best 40, count 20.
    for (int i = 0; i < 40; i++) drive_b(2'b00, 2'b01, 2'b00, 1'b0);
    drive_b(2'b01, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 20; i++) drive_b(2'b00, 2'b01, 2'b00, 1'b0);
    check("b20_count", 32'(if_b.combo_count[6:0]), 20);
    check("b40_best",  32'(if_b.best_combo[6:0]), 40);
    drive_b(2'b00, 2'b00, 2'b00, 1'b1);
    check("restart_b_count",  32'(if_b.combo_count), 0);
    check("restart_b_best",   32'(if_b.best_combo[6:0]), 40);
    check("restart_b_broken", 32'(if_b.combo_broken), 0);

    // Decay: 16 idle cycles after the last hit the count clears.
    for (int i = 0; i < 5; i++) drive_b(2'b00, 2'b01, 2'b00, 1'b0);
    for (int i = 0; i < 15; i++) drive_b(2'b00, 2'b00, 2'b00, 1'b0);
    check("decay_15_count",  32'(if_b.combo_count[6:0]), 5);
    check("decay_15_broken", 32'(if_b.combo_broken), 0);
    drive_b(2'b00, 2'b00, 2'b00, 1'b0);
    check("decay_16_count",  32'(if_b.combo_count[6:0]), 0);
    check("decay_16_broken", 32'(if_b.combo_broken), 32'h1);
    drive_b(2'b00, 2'b00, 2'b00, 1'b0);
    check("decay_pulse_end", 32'(if_b.combo_broken), 0);
    check("decay_best",      32'(if_b.best_combo[6:0]), 40);

    // Hit on the expiry cycle wins; the timer then restarts from that hit.
    for (int i = 0; i < 5; i++) drive_b(2'b00, 2'b01, 2'b00, 1'b0);
    for (int i = 0; i < 15; i++) drive_b(2'b00, 2'b00, 2'b00, 1'b0);
    drive_b(2'b00, 2'b01, 2'b00, 1'b0);
    check("expiry_hit_count",  32'(if_b.combo_count[6:0]), 6);
    check("expiry_hit_broken", 32'(if_b.combo_broken), 0);
    for (int i = 0; i < 15; i++) drive_b(2'b00, 2'b00, 2'b00, 1'b0);
    check("rearm_15_count", 32'(if_b.combo_count[6:0]), 6);
    drive_b(2'b00, 2'b00, 2'b00, 1'b0);
    check("rearm_16_count",  32'(if_b.combo_count[6:0]), 0);
    check("rearm_16_broken", 32'(if_b.combo_broken), 32'h1);
    check("b_ch1_idle",      32'(if_b.combo_count[13:7]), 0);

    // Asynchronous reset mid-cycle clears everything without a clock edge.
    for (int i = 0; i < 3; i++) drive_a(2'b00, 2'b01, 2'b00, 1'b0);
    drive_a(2'b01, 2'b00, 2'b00, 1'b0);
    check("pre_rst_broken", 32'(if_a.combo_broken), 32'h1);
    #5 rst = 1'b1;
    #1;
    check("async_a_count",  32'(if_a.combo_count), 0);
    check("async_a_best",   32'(if_a.best_combo), 0);
    check("async_a_broken", 32'(if_a.combo_broken), 0);
    check("async_a_mult",   32'(if_a.multiplier), 32'h9);
    check("async_b_best",   32'(if_b.best_combo), 0);
    #3 rst = 1'b0;
    drive_a(2'b00, 2'b00, 2'b00, 1'b0);
    check("post_async_count", 32'(if_a.combo_count), 0);
    check("post_async_mult",  32'(if_b.multiplier), 32'h9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
